// File: rtl/uart_rx_bit_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_rx_bit_sequencer_if                               |
// | Brief   : Serial-line, control and bit-strobe bundle for the     |
// |           UART receive bit sequencer.                            |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
interface uart_rx_bit_sequencer_if #(
  parameter int DIV_W = 16
);
  logic             Enable;
  logic [DIV_W-1:0] Baud_Div;
  logic             Rx_In;
  logic             Rx_Bit;
  logic             Bit_Valid;
  logic             Frame_Active;
  logic             Frame_Done;
  logic             Start_Err;

  modport master (
    output Enable, Baud_Div, Rx_In,
    input  Rx_Bit, Bit_Valid, Frame_Active, Frame_Done, Start_Err
  );

  modport slave (
    input  Enable, Baud_Div, Rx_In,
    output Rx_Bit, Bit_Valid, Frame_Active, Frame_Done, Start_Err
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_bit_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_rx_bit_sequencer                                  |
// | Brief   : Oversampled start detect, 3-sample majority vote and   |
// |           one-strobe-per-bit timing for the UART receive FSM.    |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
module uart_rx_bit_sequencer #(
  parameter int OVERSAMPLE = 16,
  parameter int FRAME_BITS = 12,
  parameter int DIV_W      = 16
) (
  input  logic                    Clk,
  input  logic                    Rst_N,
  uart_rx_bit_sequencer_if.slave  bus
);

  localparam int c_MID   = OVERSAMPLE / 2;
  localparam int c_OS_W  = $clog2(OVERSAMPLE);
  localparam int c_BIT_W = $clog2(FRAME_BITS);

  localparam logic [c_OS_W-1:0]  c_SMP0   = c_OS_W'(c_MID - 1);
  localparam logic [c_OS_W-1:0]  c_SMP1   = c_OS_W'(c_MID);
  localparam logic [c_OS_W-1:0]  c_SMP2   = c_OS_W'(c_MID + 1);
  localparam logic [c_OS_W-1:0]  c_OS_MAX = c_OS_W'(OVERSAMPLE - 1);
  localparam logic [c_BIT_W-1:0] c_LAST   = c_BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_sync;
  logic                 r_rx_d;
  logic                 w_rx_s;
  logic [DIV_W-1:0]     r_div_l;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [DIV_W-1:0]     w_div_eff;
  logic [c_OS_W-1:0]    r_os_cnt;
  logic [c_BIT_W-1:0]   r_bit_cnt;
  logic [1:0]           r_smp;
  logic                 r_rx_bit;
  logic                 r_bit_valid;
  logic                 r_frame_active;
  logic                 r_frame_done;
  logic                 r_start_err;
  logic                 w_start_det;
  logic                 w_os_tick;
  logic                 w_strobe_due;
  logic                 w_vote;
  logic                 w_emit_bit;
  logic                 w_emit_err;
  logic                 w_emit_done;

  assign w_rx_s       = r_sync[1];
  assign w_div_eff    = (bus.Baud_Div == '0) ? DIV_W'(1) : bus.Baud_Div;
  assign w_start_det  = bus.Enable && r_rx_d && !w_rx_s;
  assign w_os_tick    = (r_div_cnt == (r_div_l - DIV_W'(1)));
  assign w_strobe_due = (r_state != S_IDLE) && w_os_tick && (r_os_cnt == c_SMP2);
  // Third sample is the live synchronised line on the MID+1 tick.
  assign w_vote       = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx_s) | (r_smp[1] & w_rx_s);

  always_comb begin
    w_state_nxt = r_state;
    w_emit_bit  = 1'b0;
    w_emit_err  = 1'b0;
    w_emit_done = 1'b0;
    if (!bus.Enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_det) w_state_nxt = S_START;
        end
        S_START: begin
          if (w_strobe_due) begin
            if (w_vote) begin
              w_emit_err  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_emit_bit  = 1'b1;
              w_state_nxt = S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (w_strobe_due) begin
            w_emit_bit = 1'b1;
            if (r_bit_cnt == c_LAST) begin
              w_emit_done = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_state        <= S_IDLE;
      r_sync         <= 2'b11;
      r_rx_d         <= 1'b1;
      r_div_l        <= DIV_W'(1);
      r_div_cnt      <= '0;
      r_os_cnt       <= '0;
      r_bit_cnt      <= '0;
      r_smp          <= 2'b11;
      r_rx_bit       <= 1'b1;
      r_bit_valid    <= 1'b0;
      r_frame_active <= 1'b0;
      r_frame_done   <= 1'b0;
      r_start_err    <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], bus.Rx_In};
      r_rx_d       <= w_rx_s;
      r_state      <= w_state_nxt;
      r_bit_valid  <= w_emit_bit;
      r_start_err  <= w_emit_err;
      r_frame_done <= w_emit_done;
      if (w_emit_bit) r_rx_bit <= w_vote;

      if (!bus.Enable) begin
        r_div_cnt      <= '0;
        r_os_cnt       <= '0;
        r_bit_cnt      <= '0;
        r_frame_active <= 1'b0;
      end else if (r_state == S_IDLE) begin
        r_div_cnt <= '0;
        r_os_cnt  <= '0;
        r_bit_cnt <= '0;
        // Divider is frozen per frame so mid-frame Baud_Div writes cannot skew timing.
        if (w_start_det) begin
          r_div_l        <= w_div_eff;
          r_frame_active <= 1'b1;
        end else if (r_frame_done) begin
          r_frame_active <= 1'b0;
        end
      end else begin
        if (w_os_tick) begin
          r_div_cnt <= '0;
          r_os_cnt  <= (r_os_cnt == c_OS_MAX) ? '0 : r_os_cnt + c_OS_W'(1);
          if (r_os_cnt == c_SMP0) r_smp[0] <= w_rx_s;
          if (r_os_cnt == c_SMP1) r_smp[1] <= w_rx_s;
        end else begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
        if (w_emit_bit) r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
        if (w_emit_err) r_frame_active <= 1'b0;
      end
    end
  end

  // Pulses are masked by Enable so an abort suppresses a strobe landing in the same cycle.
  assign bus.Rx_Bit       = r_rx_bit;
  assign bus.Bit_Valid    = r_bit_valid  & bus.Enable;
  assign bus.Frame_Done   = r_frame_done & bus.Enable;
  assign bus.Start_Err    = r_start_err  & bus.Enable;
  assign bus.Frame_Active = r_frame_active;

endmodule
`default_nettype wire
